system_pio_ir_modulator: RTL and testbench
==========================================

SYSTEM_PIO_IR_MODULATOR -- requirements
Module: system_pio_ir_modulator

Interface
REQ-001 Parameter WIDTH, default 1, number of IR emitter channels (1..32).
REQ-002 Parameter DIV_WIDTH, default 16, width of the carrier divider register.
REQ-003 Parameter DEFAULT_DIV, default 657, carrier divider reset value (38 kHz carrier at 50 MHz).
REQ-004 Parameter BURST_WIDTH, default 16, width of the burst length counter.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 address  in  2  Avalon-MM register select.
REQ-009 chipselect  in  1  slave select; qualifies writes.
REQ-010 write_n  in  1  active-low write strobe.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  combinational read data for the current address; unused bits zero.
REQ-013 out_port  out  WIDTH  emitter drive, one bit per channel.
REQ-014 irq  out  1  level interrupt = done AND irq_en.

Function
REQ-015 A write SHALL occur on a clock edge with chipselect=1, write_n=0; no wait states.
REQ-016 Addr 0 DATA: R/W, bits [WIDTH-1:0] = channel enable register data_out.
REQ-017 Addr 1 DIV: R/W, bits [DIV_WIDTH-1:0]; carrier half-period = DIV+1 clocks.
REQ-018 Addr 2 BURST: write = start/abort; read returns the remaining carrier periods.
REQ-019 Addr 3 CTRL: bit0 mod_en (RW), bit1 burst_en (RW), bit2 done (RO sticky, write 1 clears), bit3 irq_en (RW), bit4 busy (RO).
REQ-020 Carrier counter cnt SHALL count 0..DIV; at cnt==DIV it reloads 0 and carrier toggles.
REQ-021 A DIV write SHALL load DIV and force cnt=0, carrier=0 on the same edge.
REQ-022 DIV=0 SHALL give a carrier toggling every clock (period 2 clocks).
REQ-023 gate SHALL equal 1 when burst_en=0, else busy.
REQ-024 out_port[i] SHALL equal data_out[i] AND gate when mod_en=0, and data_out[i] AND gate AND carrier when mod_en=1; it is registered, so it changes one clock after its inputs.
REQ-025 A BURST write with writedata[BURST_WIDTH-1:0]=N≠0 SHALL set remaining=N, busy=1, cnt=0, carrier=1, whether or not a burst is active.
REQ-026 While busy, each carrier 1->0 toggle SHALL decrement remaining by 1.
REQ-027 When a decrement takes remaining from 1 to 0, busy SHALL clear and done SHALL set on the same edge.
REQ-028 A BURST write with N=0 SHALL abort: remaining=0, busy=0, done unchanged.
REQ-029 If done is set and cleared on the same edge, set SHALL win.
REQ-030 If a BURST write and a terminal decrement coincide, the write SHALL win (restart) and done SHALL NOT set.
REQ-031 Writes to read-only bits SHALL be ignored.
REQ-032 A DIV write during a burst SHALL realign the carrier per REQ-021 and SHALL NOT change remaining.

Reset
REQ-033 On reset_n=0, asynchronously: data_out=0, DIV=DEFAULT_DIV, cnt=0, carrier=0, remaining=0, busy=0, done=0, CTRL RW bits=0.
REQ-034 During reset, out_port=0 and irq=0; readdata reflects the reset register values.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no done set.

Verification
REQ-036 Reset, then read addr 1 -> 657; addr 3 -> 0; out_port=0, irq=0.
REQ-037 mod_en=0, burst_en=0, write DATA=1 -> out_port[0]=1 one clock later and held high, no toggling.
REQ-038 DIV=3, mod_en=1, DATA=1 -> out_port[0] toggles every 4 clocks (period 8) after the first 4-clock low phase.
REQ-039 DIV=1, mod_en=1, burst_en=1, irq_en=1, DATA=1, BURST=3 -> exactly 3 high pulses of 2 clocks; then busy=0, done=1, irq=1, out_port=0; write CTRL bit2=1 -> irq=0.
REQ-040 BURST=5 then BURST=0 after 1 period -> out_port=0, busy=0, done=0, irq stays 0.
REQ-041 reset_n pulsed low mid-burst (BURST=100) -> all outputs 0 immediately, remaining=0, done=0.

Source files
------------

// File: rtl/system_pio_ir_modulator_if.sv
// system_pio_ir_modulator_if: Avalon-MM slave bus carrying register
// accesses to the IR modulator.
interface system_pio_ir_modulator_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/system_pio_ir_modulator.sv
// system_pio_ir_modulator: PIO that drives IR emitters with a programmable
// carrier, optionally gated by a burst counter that raises a done interrupt.
module system_pio_ir_modulator #(
    parameter int WIDTH       = 1,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 657,
    parameter int BURST_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    system_pio_ir_modulator_if.slave bus,
    output logic [WIDTH-1:0]         out_port,
    output logic                     irq
);
    logic [WIDTH-1:0]       data_out;
    logic [DIV_WIDTH-1:0]   div, cnt;
    logic [BURST_WIDTH-1:0] remaining, burst_n;
    logic carrier, busy, done, mod_en, burst_en, irq_en;
    logic wr, wr_data, wr_div, wr_burst, wr_ctrl, wrap, dec, term, gate, unused_wd;
    always_comb begin
        wr        = bus.chipselect & ~bus.write_n;
        wr_data   = wr && bus.address == 2'd0;
        wr_div    = wr && bus.address == 2'd1;
        wr_burst  = wr && bus.address == 2'd2;
        wr_ctrl   = wr && bus.address == 2'd3;
        burst_n   = bus.writedata[BURST_WIDTH-1:0];
        wrap      = cnt == div;
        // a realigning write owns the carrier this edge, so a pending fall is dropped
        dec       = busy & wrap & carrier & ~wr_div & ~wr_burst;
        term      = dec && remaining == BURST_WIDTH'(1);
        gate      = burst_en ? busy : 1'b1;
        irq       = done & irq_en;
        unused_wd = ^bus.writedata;
        bus.readdata = bus.address == 2'd0 ? 32'(data_out) :
                       bus.address == 2'd1 ? 32'(div) :
                       bus.address == 2'd2 ? 32'(remaining) :
                       {27'd0, busy, irq_en, done, burst_en, mod_en};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= '0;
            div       <= DIV_WIDTH'(DEFAULT_DIV);
            cnt       <= '0;
            carrier   <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mod_en    <= 1'b0;
            burst_en  <= 1'b0;
            irq_en    <= 1'b0;
            out_port  <= '0;
        end else begin
            if (wr_data) data_out <= bus.writedata[WIDTH-1:0];
            if (wr_div) div <= bus.writedata[DIV_WIDTH-1:0];
            if (wr_ctrl) {irq_en, burst_en, mod_en} <= {bus.writedata[3], bus.writedata[1:0]};
            if (wr_div || (wr_burst && burst_n != '0)) begin
                cnt     <= '0;
                carrier <= ~wr_div;
            end else begin
                cnt     <= wrap ? '0 : cnt + DIV_WIDTH'(1);
                carrier <= carrier ^ wrap;
            end
            if (wr_burst) begin
                remaining <= burst_n;
                busy      <= burst_n != '0;
            end else if (dec) begin
                remaining <= remaining - BURST_WIDTH'(1);
                busy      <= ~term;
            end
            done     <= term | (done & ~(wr_ctrl & bus.writedata[2]));
            out_port <= data_out & {WIDTH{gate & (~mod_en | carrier)}};
        end
    end
endmodule

// File: tb/tb_system_pio_ir_modulator.sv
// tb_system_pio_ir_modulator: scoreboard bench; a closed-form carrier/burst
// model predicts out_port, irq and readdata for every clock edge.
module tb_system_pio_ir_modulator;
    localparam int W = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [W-1:0] out_port;
    logic irq;
    system_pio_ir_modulator_if bus();
    system_pio_ir_modulator #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port), .irq(irq)
    );
    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] o; logic i; logic [31:0] rd; logic [1:0] a; } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;
    bit stim_done = 1'b0;

    // carrier phase is derived from the edge count since the last realignment
    int t, t_a, c0, rem_a, div_m, rem_now;
    logic [W-1:0] m_data;
    bit m_mod, m_ben, m_ien, m_done, car_now, busy_now;

    task automatic model_reset();
        t = 0; t_a = 0; c0 = 0; rem_a = 0; div_m = 657; rem_now = 0;
        m_data = '0; m_mod = 0; m_ben = 0; m_ien = 0; m_done = 0; car_now = 0; busy_now = 0;
    endtask

    function automatic logic [31:0] model_read(logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_data);
            2'd1:    return 32'(div_m);
            2'd2:    return 32'(rem_now);
            default: return {27'd0, busy_now, m_ien, m_done, m_ben, m_mod};
        endcase
    endfunction

    task automatic model_edge(bit we, logic [1:0] a, logic [31:0] d);
        exp_t e;
        int tog, falls, n;
        bit bw;
        if (!reset_n) begin
            model_reset();
            e.o = '0;
        end else begin
            e.o = m_data & {W{(m_ben ? busy_now : 1'b1) & (m_mod ? car_now : 1'b1)}};
            t++;
            bw = we && a == 2'd2;
            if (we && a == 2'd0) m_data = d[W-1:0];
            if (we && a == 2'd1) begin
                div_m = int'(d[15:0]); t_a = t; c0 = 0; rem_a = rem_now;
            end
            if (bw) begin
                n = int'(d[15:0]);
                if (n != 0) begin t_a = t; c0 = 1; end
                rem_a = n;
            end
            tog = (t - t_a) / (div_m + 1);
            car_now = c0[0] ^ tog[0];
            falls = (tog + c0) / 2;
            rem_now = rem_a > falls ? rem_a - falls : 0;
            m_done = (busy_now && rem_now == 0 && !bw) || (m_done && !(we && a == 2'd3 && d[2]));
            if (we && a == 2'd3) {m_ien, m_ben, m_mod} = {d[3], d[1], d[0]};
            busy_now = rem_now != 0;
        end
        e.i = m_done & m_ien;
        e.rd = model_read(a);
        e.a = a;
        q.push_back(e);
    endtask

    task automatic cyc(bit we, logic [1:0] a, logic [31:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.chipselect = we ? 1'b1 : 1'($urandom_range(0, 1));
        bus.write_n = we ? 1'b0 : (bus.chipselect ? 1'b1 : 1'($urandom_range(0, 1)));
        @(posedge clk);
        model_edge(we, a, d);
        @(negedge clk);
    endtask

    task automatic idle(int n, logic [1:0] a);
        repeat (n) cyc(1'b0, a, $urandom());
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        cyc(1'b1, a, d);
    endtask

    initial begin
        exp_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                if (!stim_done) begin
                    total++; bad++;
                    $display("FAIL scoreboard: no expectation queued at %0t", $time);
                end
            end else begin
                e = q.pop_front();
                total++;
                if (out_port !== e.o) begin
                    bad++;
                    $display("FAIL out_port at %0t: got %h expected %h", $time, out_port, e.o);
                end
                total++;
                if (irq !== e.i) begin
                    bad++;
                    $display("FAIL irq at %0t: got %b expected %b", $time, irq, e.i);
                end
                total++;
                if (bus.readdata !== e.rd) begin
                    bad++;
                    $display("FAIL readdata addr %0d at %0t: got %h expected %h", e.a, $time, bus.readdata, e.rd);
                end
            end
        end
    end

    initial begin
        logic [1:0] a;
        logic [31:0] d;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        model_reset();
        @(negedge clk);
        idle(2, 2'd1);
        reset_n = 1'b1;
        idle(2, 2'd1);
        idle(2, 2'd3);
        wr(2'd0, 32'd1); idle(6, 2'd0);
        wr(2'd1, 32'd3); wr(2'd3, 32'h1); idle(20, 2'd2);
        wr(2'd1, 32'd1); wr(2'd3, 32'hb); wr(2'd2, 32'd3); idle(20, 2'd3);
        wr(2'd3, 32'hf); idle(3, 2'd3);
        wr(2'd2, 32'd5); idle(4, 2'd2); wr(2'd2, 32'd0); idle(6, 2'd3);
        wr(2'd3, 32'h2); wr(2'd2, 32'd100); idle(10, 2'd2);
        reset_n = 1'b0;
        #1;
        total++;
        if (out_port !== '0 || irq !== 1'b0 || bus.readdata !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: got out_port=%h irq=%b remaining=%0d expected 0 0 0", out_port, irq, bus.readdata);
        end
        idle(2, 2'd2);
        reset_n = 1'b1;
        idle(2, 2'd3);
        for (int i = 0; i < 3000; i++) begin
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                idle(1, a);
                reset_n = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                case (a)
                    2'd0:    d = $urandom();
                    2'd1:    d = ($urandom() & 32'hffff0000) | $urandom_range(0, 4);
                    2'd2:    d = ($urandom() & 32'hffff0000) | $urandom_range(0, 6);
                    default: d = $urandom_range(0, 31);
                endcase
                wr(a, d);
            end else begin
                idle(1, a);
            end
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
